// File: rtl/fwrisc_wb_arb_pkg.sv
// Shared types and constants for the 2:1 Wishbone arbiter.
package fwrisc_wb_arb_pkg;

  // Arbiter ownership states: nobody, instruction port, data port.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_e;

  // Encoding of the last-grant register.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/fwrisc_wb_arb.sv
// 2:1 Wishbone arbiter: instruction (i_) and data (d_) initiators share one
// target port (m_). Every transfer is arbitrated on its own, with a one-cycle
// idle gap between transfers. An optional watchdog ends transfers the target
// never acknowledges.
module fwrisc_wb_arb
  import fwrisc_wb_arb_pkg::*;
#(
  parameter bit          DPRIO   = 1'b1,
  parameter int          TIMEOUT = 0,
  parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  // instruction initiator
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat_w,
  input  logic [3:0]  i_sel,
  input  logic        i_we,
  input  logic        i_cyc,
  input  logic        i_stb,
  output logic [31:0] i_dat_r,
  output logic        i_ack,
  // data initiator
  input  logic [31:0] d_adr,
  input  logic [31:0] d_dat_w,
  input  logic [3:0]  d_sel,
  input  logic        d_we,
  input  logic        d_cyc,
  input  logic        d_stb,
  output logic [31:0] d_dat_r,
  output logic        d_ack,
  // shared target
  output logic [31:0] m_adr,
  output logic [31:0] m_dat_w,
  output logic [3:0]  m_sel,
  output logic        m_we,
  output logic        m_cyc,
  output logic        m_stb,
  input  logic [31:0] m_dat_r,
  input  logic        m_ack,
  // watchdog event
  output logic        timeout
);

  // The counter must be able to hold TIMEOUT so it never wraps; when the
  // watchdog is disabled a one-bit counter parked at zero is kept.
  localparam bit            WD_EN   = (TIMEOUT > 0);
  localparam int            WD_W    = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? TIMEOUT - 1 : 0);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic             r_last_grant;
  logic             w_last_grant_nxt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [WD_W-1:0]  w_wd_cnt_nxt;

  logic w_req_i;
  logic w_req_d;
  logic w_owned;
  logic w_own_cyc;
  logic w_wd_fire;

  assign w_req_i   = i_cyc & i_stb;
  assign w_req_d   = d_cyc & d_stb;
  assign w_owned   = (r_state == ARB_OWN_I) || (r_state == ARB_OWN_D);
  assign w_own_cyc = (r_state == ARB_OWN_I) ? i_cyc :
                     (r_state == ARB_OWN_D) ? d_cyc : 1'b0;

  // A genuine ack in the firing cycle wins; an aborted cycle is not timed out.
  assign w_wd_fire = WD_EN && w_owned && w_own_cyc && !m_ack && (r_wd_cnt == WD_LAST);

  // State, last-grant and watchdog registers.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= PORT_I;
      r_wd_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
    end
  end

  // Next-state logic: grant from IDLE, release on ack, abort or watchdog.
  always_comb begin
    // NOTE: defaults first so that no branch leaves a signal unassigned,
    // which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_wd_cnt_nxt     = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_req_d && (!w_req_i || DPRIO || (r_last_grant == PORT_I))) begin
          w_state_nxt      = ARB_OWN_D;
          w_last_grant_nxt = PORT_D;
        end else if (w_req_i) begin
          w_state_nxt      = ARB_OWN_I;
          w_last_grant_nxt = PORT_I;
        end
      end
      ARB_OWN_I, ARB_OWN_D: begin
        if (WD_EN && !m_ack) begin
          w_wd_cnt_nxt = r_wd_cnt + 1'b1;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt;
        end
        if (!w_own_cyc || m_ack || w_wd_fire) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Output mux: the owner drives the target, the target answers the owner.
  always_comb begin
    m_adr   = '0;
    m_dat_w = '0;
    m_sel   = '0;
    m_we    = 1'b0;
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    i_dat_r = '0;
    i_ack   = 1'b0;
    d_dat_r = '0;
    d_ack   = 1'b0;
    timeout = w_wd_fire;
    case (r_state)
      ARB_OWN_I: begin
        m_adr   = i_adr;
        m_dat_w = i_dat_w;
        m_sel   = i_sel;
        m_we    = i_we;
        m_cyc   = i_cyc & ~w_wd_fire;
        m_stb   = i_stb & ~w_wd_fire;
        i_ack   = m_ack | w_wd_fire;
        i_dat_r = w_wd_fire ? TO_DATA : m_dat_r;
      end
      ARB_OWN_D: begin
        m_adr   = d_adr;
        m_dat_w = d_dat_w;
        m_sel   = d_sel;
        m_we    = d_we;
        m_cyc   = d_cyc & ~w_wd_fire;
        m_stb   = d_stb & ~w_wd_fire;
        d_ack   = m_ack | w_wd_fire;
        d_dat_r = w_wd_fire ? TO_DATA : m_dat_r;
      end
      default: ;
    endcase
  end

endmodule
